// File: rtl/fft_peak_detect.sv
// Streaming peak finder over the lower half of each FFT frame.
// Define FFT_PEAK_DC_SKIP_EN to exclude bin 0 from the candidates.
`timescale 1ns/1ps
module fft_peak_detect #(
    parameter int N_LOG2 = 12
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [15:0]       fft_out_data,
    input  logic              fft_out_valid,
    input  logic              fft_out_last,
    output logic              fft_out_ready,
    output logic [N_LOG2-1:0] peak_bin,
    output logic [15:0]       peak_mag,
    output logic              peak_valid,
    output logic              frame_err
);

    localparam logic [N_LOG2-1:0] BIN_TOP = '1;
`ifdef FFT_PEAK_DC_SKIP_EN
    localparam logic [N_LOG2-1:0] IDX_INIT = N_LOG2'(1);
`else
    localparam logic [N_LOG2-1:0] IDX_INIT = '0;
`endif

    logic              ready_q;
    logic [N_LOG2-1:0] cnt_q, cnt_d;

    logic signed [7:0] s1_re_q, s1_im_q;
    logic [N_LOG2-1:0] s1_bin_q;
    logic              s1_end_q, s1_err_q, s1_vld_q;

    logic [15:0]       s2_sqr_q, s2_sqi_q;
    logic [N_LOG2-1:0] s2_bin_q;
    logic              s2_end_q, s2_err_q, s2_vld_q;

    logic [15:0]       s3_mag_q;
    logic [N_LOG2-1:0] s3_bin_q;
    logic              s3_end_q, s3_err_q, s3_vld_q;

    logic [15:0]       max_q, max_d, max_new;
    logic [N_LOG2-1:0] idx_q, idx_d, idx_new;

    logic [N_LOG2-1:0] peak_bin_q;
    logic [15:0]       peak_mag_q;
    logic              peak_valid_q, frame_err_q;

    logic              accept, at_top, frame_end, len_err;
    logic signed [15:0] re_x, im_x;
    logic [15:0]       sqr_d, sqi_d;
    logic              cand, hit;

    assign accept    = fft_out_valid & ready_q;
    assign at_top    = (cnt_q == BIN_TOP);
    assign frame_end = fft_out_last | at_top;
    assign len_err   = fft_out_last ^ at_top;
    assign cnt_d     = frame_end ? '0 : cnt_q + N_LOG2'(1);

    assign re_x  = 16'(s1_re_q);
    assign im_x  = 16'(s1_im_q);
    assign sqr_d = $unsigned(re_x * re_x);
    assign sqi_d = $unsigned(im_x * im_x);

    // Only the lower half of the spectrum competes for the peak.
`ifdef FFT_PEAK_DC_SKIP_EN
    assign cand = ~s3_bin_q[N_LOG2-1] & (s3_bin_q != '0);
`else
    assign cand = ~s3_bin_q[N_LOG2-1];
`endif
    assign hit     = s3_vld_q & cand & (s3_mag_q > max_q);
    assign max_new = hit ? s3_mag_q : max_q;
    assign idx_new = hit ? s3_bin_q : idx_q;

    always_comb begin
        max_d = max_new;
        idx_d = idx_new;
        if (s3_vld_q && s3_end_q) begin
            max_d = '0;
            idx_d = IDX_INIT;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ready_q      <= 1'b0;
            cnt_q        <= '0;
            s1_re_q      <= '0;
            s1_im_q      <= '0;
            s1_bin_q     <= '0;
            s1_end_q     <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_vld_q     <= 1'b0;
            s2_sqr_q     <= '0;
            s2_sqi_q     <= '0;
            s2_bin_q     <= '0;
            s2_end_q     <= 1'b0;
            s2_err_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            s3_mag_q     <= '0;
            s3_bin_q     <= '0;
            s3_end_q     <= 1'b0;
            s3_err_q     <= 1'b0;
            s3_vld_q     <= 1'b0;
            max_q        <= '0;
            idx_q        <= IDX_INIT;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            ready_q  <= 1'b1;
            s1_vld_q <= accept;
            if (accept) begin
                cnt_q    <= cnt_d;
                s1_re_q  <= fft_out_data[7:0];
                s1_im_q  <= fft_out_data[15:8];
                s1_bin_q <= cnt_q;
                s1_end_q <= frame_end;
                s1_err_q <= len_err;
            end

            s2_vld_q <= s1_vld_q;
            s2_sqr_q <= sqr_d;
            s2_sqi_q <= sqi_d;
            s2_bin_q <= s1_bin_q;
            s2_end_q <= s1_end_q;
            s2_err_q <= s1_err_q;

            s3_vld_q <= s2_vld_q;
            s3_mag_q <= s2_sqr_q + s2_sqi_q;
            s3_bin_q <= s2_bin_q;
            s3_end_q <= s2_end_q;
            s3_err_q <= s2_err_q;

            max_q <= max_d;
            idx_q <= idx_d;

            peak_valid_q <= s3_vld_q & s3_end_q;
            frame_err_q  <= s3_vld_q & s3_end_q & s3_err_q;
            if (s3_vld_q && s3_end_q) begin
                peak_bin_q <= idx_new;
                peak_mag_q <= max_new;
            end
        end
    end

    assign fft_out_ready = ready_q;
    assign peak_bin      = peak_bin_q;
    assign peak_mag      = peak_mag_q;
    assign peak_valid    = peak_valid_q;
    assign frame_err     = frame_err_q;

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter N_LOG2, default 12, log2 of FFT frame length N (N=4096 default).
REQ-002 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fft_out_data  input  16  FFT result beat: [7:0] real, [15:8] imag, both two's complement.
REQ-005 SHALL have port fft_out_valid  input  1  AXI-stream tvalid from FFT.
REQ-006 SHALL have port fft_out_last  input  1  AXI-stream tlast, marks final bin of frame.
REQ-007 SHALL have port fft_out_ready  output  1  AXI-stream tready to FFT.
REQ-008 SHALL have port peak_bin  output  N_LOG2  index of strongest bin of last completed frame.
REQ-009 SHALL have port peak_mag  output  16  unsigned re^2+im^2 of peak_bin.
REQ-010 SHALL have port peak_valid  output  1  one-cycle pulse, peak_bin/peak_mag updated.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse coincident with peak_valid when frame length != N.

Function
REQ-012 SHALL define a beat as accepted only when fft_out_valid and fft_out_ready are both 1 on a rising edge.
REQ-013 SHALL drive fft_out_ready 1 in every cycle after reset release; 0 while rst_in is low.
REQ-014 SHALL keep bin counter bin_cnt (N_LOG2 bits), 0 at frame start, +1 per accepted beat.
REQ-015 SHALL compute per beat mag = re*re + im*im as signed products summed into 16 unsigned bits (max 32768, no overflow).
REQ-016 SHALL pipeline: stage 1 registers re, im, bin_cnt, last flag; stage 2 registers squares; stage 3 sums and compares.
REQ-017 SHALL consider only bins 0..N/2-1 as peak candidates; bins N/2..N-1 are accepted and counted but never compared.
REQ-018 SHALL update running max only when mag > running max (strict), so ties keep the lowest bin index.
REQ-019 SHALL end a frame on an accepted beat with fft_out_last=1, or on the accepted beat where bin_cnt=N-1, whichever comes first.
REQ-020 SHALL pulse peak_valid exactly 3 cycles after the rising edge accepting the frame-ending beat, peak outputs valid in that cycle.
REQ-021 SHALL pulse frame_err with peak_valid when fft_out_last=1 arrived with bin_cnt!=N-1, or bin_cnt=N-1 arrived with fft_out_last=0.
REQ-022 SHALL, at frame end, reset bin_cnt and running max to 0 so the next accepted beat is bin 0 of a new frame; back-to-back frames with no idle cycle SHALL be handled without loss.
REQ-023 SHALL hold peak_bin/peak_mag stable between peak_valid pulses.
REQ-024 SHALL report peak_bin=0, peak_mag=0 for a frame whose candidate bins are all zero.
REQ-025 SHALL ignore fft_out_data/fft_out_last on cycles without an accepted beat; pipeline bubbles SHALL not affect results.

Reset
REQ-026 SHALL, while rst_in low, asynchronously clear bin_cnt, running max/index, all pipeline registers, peak_bin=0, peak_mag=0, peak_valid=0, frame_err=0, fft_out_ready=0.
REQ-027 SHALL discard any partial frame and in-flight pipeline beats on reset; first accepted beat after release is bin 0.

Configuration
REQ-028 SHALL, with macro FFT_PEAK_DC_SKIP_EN defined, exclude bin 0 from candidates (range 1..N/2-1); all-zero frame reports peak_bin=1, peak_mag=0.
REQ-029 SHALL, without FFT_PEAK_DC_SKIP_EN, include bin 0 per REQ-017.

Verification
REQ-030 SHALL cover: N=4096 frame, bin 440 = 0x0030 (re=48), rest 0, last on bin 4095 -> peak_bin=440, peak_mag=2304, frame_err=0, peak_valid 3 cycles after last.
REQ-031 SHALL cover: bins 100 and 200 both re=-128,im=-128 -> peak_bin=100, peak_mag=32768.
REQ-032 SHALL cover: bin 3000 = 0x7F7F, bin 10 = 0x0101 -> peak_bin=10, peak_mag=2 (upper half ignored).
REQ-033 SHALL cover: last asserted on beat 999 -> peak_valid with frame_err=1; next frame starts at bin 0 and reports correctly.
REQ-034 SHALL cover: rst_in pulsed low mid-frame at bin 2000 -> no peak_valid for that frame; following full frame reports correct peak.
REQ-035 SHALL cover: bin 0 = 0x0050 (re=80), bin 5 = 0x0001 -> peak_bin=0, mag=6400 without FFT_PEAK_DC_SKIP_EN; peak_bin=5, mag=1 with it.
